kamus_id_queue: RTL and testbench
=================================

KAMUS_ID_QUEUE -- requirements
Module: kamus_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: decoded-instruction queue entries; power of two, 2..16.
REQ-002 SHALL have parameter PC_WIDTH, default 32: width of PC ports.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
REQ-004 SHALL have these fetch-side ports:
- instr_valid_i  in  1  fetch offers an instruction.
- instr_ready_o  out  1  queue accepts it.
- instr_i  in  32  raw instruction.
- instr_addr_i  in  PC_WIDTH  instruction PC.
- next_pc_i  in  PC_WIDTH  fetch next PC.
REQ-005 SHALL have these issue-side ports:
- dec_valid_o  out  1  head entry issuable.
- dec_ready_i  in  1  EX accepts head.
- instr_o  out  instr_decoded_t  head operation/immediate/immediate_used/pc.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  head register fields.
- next_pc_o  out  PC_WIDTH  head next PC.
- illegal_o  out  1  head operation is INVALID.
REQ-006 SHALL have these control ports:
- flush_i  in  1  discard all entries.
- ex_load_valid_i  in  1  a load occupies EX.
- ex_load_rd_i  in  5  destination of that load.
- count_o  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-007 SHALL decode on enqueue: operation and immediate per kamus_pkg RV32I rules (opext != 2'b11 -> INVALID; immediates sign-extended except U-type; immediate_used per format); the decoded result is stored, not raw bits.
REQ-008 SHALL handshake: push when instr_valid_i && instr_ready_o; pop when dec_valid_o && dec_ready_i; both may occur in one cycle; count_o is unchanged in that case.
REQ-009 SHALL set instr_ready_o = !full && state==RUN && !flush_i; there is no pass-through when full, even if a pop occurs the same cycle.
REQ-010 SHALL have latency 1: an instruction pushed in cycle N is at the head no earlier than N+1; head outputs come directly from storage registers.
REQ-011 SHALL wrap read/write pointers modulo DEPTH; full when count_o==DEPTH; empty when count_o==0.
REQ-012 SHALL define rs1 as used for all operations except LUI, AUIPC, JAL, FENCE, FENCE_I, ECALL, EBREAK; rs2 as used for branches, stores and register-register ALU ops only.
REQ-013 SHALL assert hazard when ex_load_valid_i && ex_load_rd_i!=0 && the head uses a source equal to ex_load_rd_i; x0 never hazards.
REQ-014 SHALL set dec_valid_o = !empty && !hazard && !flush_i.
REQ-015 SHALL drive illegal_o with the head; INVALID entries still issue normally.
REQ-016 SHALL implement FSM RUN/HALT: in RUN, pushing an INVALID instruction moves the FSM to HALT; in HALT, instr_ready_o=0 and queued entries keep draining; flush_i returns the FSM to RUN.
REQ-017 SHALL give flush_i priority over everything: the next cycle count_o=0, pointers are 0 and the FSM is RUN; a same-cycle push is dropped and no pop occurs.
REQ-018 SHALL hold the head outputs stable while dec_valid_o && !dec_ready_i.
REQ-019 SHALL drive don't-care head fields as 0 when empty; immediate is 0 when immediate_used=0.

Reset
REQ-020 SHALL asynchronously clear everything while rst_ni=0: pointers 0, count_o 0, FSM RUN, dec_valid_o 0, illegal_o 0, all head outputs 0.
REQ-021 SHALL drive instr_ready_o=1 from the first clock edge after rst_ni rises.
REQ-022 SHALL discard in-flight entries on reset mid-operation; no stale entry issues afterwards.

Verification
REQ-023 SHALL pass this scenario: push 0x00500093 at PC 0x100, dec_ready_i=1 -> next cycle dec_valid_o=1, operation ADD, immediate 5, immediate_used 1, rd 1, rs1 0, pc 0x100.
REQ-024 SHALL pass this scenario: dec_ready_i=0, push DEPTH instructions -> count_o=4, instr_ready_o=0; then pop one and offer one in the same cycle -> not accepted; count_o=3.
REQ-025 SHALL pass this scenario: head 0x001101B3 (ADD x3,x2,x1), ex_load_valid_i=1, ex_load_rd_i=2 -> dec_valid_o=0; with ex_load_rd_i=0 -> dec_valid_o=1.
REQ-026 SHALL pass this scenario: push 0x00000000 then 0x00500093 -> first entry issues with illegal_o=1; second not accepted (HALT); flush_i -> count_o=0 and instr_ready_o=1 the next cycle.
REQ-027 SHALL pass this scenario: 3 entries queued, flush_i together with a valid push -> next cycle count_o=0 and dec_valid_o=0.
REQ-028 SHALL pass this scenario: 2 entries queued, rst_ni pulsed low mid-cycle -> outputs are 0 immediately, asynchronously; after release the first new push issues correctly.

Source files
------------

// File: rtl/kamus_id_queue.sv
// kamus_pkg: RV32I operation encoding, decoded-instruction payload and queue entry.
// kamus_id_queue: decode-on-enqueue instruction queue between fetch and EX.
//   clk_i, rst_ni                     clock, async active-low reset
//   instr_valid_i/ready_o, instr_i,
//   instr_addr_i, next_pc_i           fetch-side push
//   dec_valid_o/ready_i, instr_o,
//   rs1/rs2/rd_addr_o, next_pc_o,
//   illegal_o                         issue-side head entry
//   flush_i, ex_load_valid_i,
//   ex_load_rd_i, count_o             flush, load-use interlock, occupancy
package kamus_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [5:0] {
        OP_INVALID, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK
    } op_e;

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} fmt_e;

    typedef struct packed {
        op_e             operation;
        logic [XLEN-1:0] immediate;
        logic            immediate_used;
        logic [XLEN-1:0] pc;
    } instr_decoded_t;

    typedef struct packed {
        instr_decoded_t   dec;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_used;
        logic             rs2_used;
        logic [XLEN-1:0]  next_pc;
    } id_entry_t;

    // Full RV32I decode of one raw instruction into a queue entry.
    function automatic id_entry_t decode(input logic [31:0] instr,
                                         input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] npc);
        id_entry_t e;
        op_e       op;
        fmt_e      fmt;
        logic [2:0] f3;
        logic [6:0] f7;
        op  = OP_INVALID;
        fmt = FMT_NONE;
        f3  = instr[14:12];
        f7  = instr[31:25];
        if (instr[1:0] == 2'b11) begin
            case (instr[6:2])
                5'b01101: begin op = OP_LUI;   fmt = FMT_U; end
                5'b00101: begin op = OP_AUIPC; fmt = FMT_U; end
                5'b11011: begin op = OP_JAL;   fmt = FMT_J; end
                5'b11001: if (f3 == 3'b000) begin op = OP_JALR; fmt = FMT_I; end
                5'b11000: begin
                    fmt = FMT_B;
                    case (f3)
                        3'b000:  op = OP_BEQ;
                        3'b001:  op = OP_BNE;
                        3'b100:  op = OP_BLT;
                        3'b101:  op = OP_BGE;
                        3'b110:  op = OP_BLTU;
                        3'b111:  op = OP_BGEU;
                        default: op = OP_INVALID;
                    endcase
                end
                5'b00000: begin
                    fmt = FMT_I;
                    case (f3)
                        3'b000:  op = OP_LB;
                        3'b001:  op = OP_LH;
                        3'b010:  op = OP_LW;
                        3'b100:  op = OP_LBU;
                        3'b101:  op = OP_LHU;
                        default: op = OP_INVALID;
                    endcase
                end
                5'b01000: begin
                    fmt = FMT_S;
                    case (f3)
                        3'b000:  op = OP_SB;
                        3'b001:  op = OP_SH;
                        3'b010:  op = OP_SW;
                        default: op = OP_INVALID;
                    endcase
                end
                5'b00100: begin
                    fmt = FMT_I;
                    case (f3)
                        3'b000: op = OP_ADD;
                        3'b010: op = OP_SLT;
                        3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;
                        3'b110: op = OP_OR;
                        3'b111: op = OP_AND;
                        3'b001: begin
                            fmt = FMT_SH;
                            if (f7 == 7'b0000000) op = OP_SLL;
                        end
                        default: begin
                            fmt = FMT_SH;
                            if (f7 == 7'b0000000)      op = OP_SRL;
                            else if (f7 == 7'b0100000) op = OP_SRA;
                        end
                    endcase
                end
                5'b01100: begin
                    if (f7 == 7'b0000000) begin
                        case (f3)
                            3'b000:  op = OP_ADD;
                            3'b001:  op = OP_SLL;
                            3'b010:  op = OP_SLT;
                            3'b011:  op = OP_SLTU;
                            3'b100:  op = OP_XOR;
                            3'b101:  op = OP_SRL;
                            3'b110:  op = OP_OR;
                            default: op = OP_AND;
                        endcase
                    end else if (f7 == 7'b0100000) begin
                        if (f3 == 3'b000)      op = OP_SUB;
                        else if (f3 == 3'b101) op = OP_SRA;
                    end
                end
                5'b00011: begin
                    if (f3 == 3'b000)      op = OP_FENCE;
                    else if (f3 == 3'b001) op = OP_FENCE_I;
                end
                5'b11100: begin
                    if (instr == 32'h0000_0073)      op = OP_ECALL;
                    else if (instr == 32'h0010_0073) op = OP_EBREAK;
                end
                default: op = OP_INVALID;
            endcase
        end
        if (op == OP_INVALID) fmt = FMT_NONE;

        e = '0;
        e.dec.operation = op;
        e.dec.pc        = pc;
        e.next_pc       = npc;
        e.rs1           = instr[19:15];
        e.rs2           = instr[24:20];
        e.rd            = instr[11:7];
        e.dec.immediate_used = (fmt != FMT_NONE);
        case (fmt)
            FMT_I:   e.dec.immediate = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   e.dec.immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   e.dec.immediate = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   e.dec.immediate = {instr[31:12], 12'b0};
            FMT_J:   e.dec.immediate = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_SH:  e.dec.immediate = {27'b0, instr[24:20]};
            default: e.dec.immediate = '0;
        endcase
        e.rs1_used = !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK});
        e.rs2_used = (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_SB, OP_SH, OP_SW})
                  || ((op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND})
                      && (fmt == FMT_NONE));
        return e;
    endfunction
endpackage

module kamus_id_queue
    import kamus_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    input  logic [31:0]                 instr_i,
    input  logic [PC_WIDTH-1:0]         instr_addr_i,
    input  logic [PC_WIDTH-1:0]         next_pc_i,
    output logic                        dec_valid_o,
    input  logic                        dec_ready_i,
    output instr_decoded_t              instr_o,
    output logic [4:0]                  rs1_addr_o,
    output logic [4:0]                  rs2_addr_o,
    output logic [4:0]                  rd_addr_o,
    output logic [PC_WIDTH-1:0]         next_pc_o,
    output logic                        illegal_o,
    input  logic                        flush_i,
    input  logic                        ex_load_valid_i,
    input  logic [4:0]                  ex_load_rd_i,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    id_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    state_e           state_q, state_d;
    logic             ready_en_q;   // holds instr_ready_o low until the first edge out of reset

    id_entry_t push_entry, head;
    logic      full, empty, hazard, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign push_entry = decode(instr_i, XLEN'(instr_addr_i), XLEN'(next_pc_i));

    // Head view: straight from storage, zeroed when nothing is queued.
    always_comb begin
        head = '0;
        if (!empty) head = mem_q[rd_ptr_q];
    end

    // Load-use interlock against the load currently in EX.
    assign hazard = ex_load_valid_i && (ex_load_rd_i != '0)
                 && ((head.rs1_used && (head.rs1 == ex_load_rd_i))
                  || (head.rs2_used && (head.rs2 == ex_load_rd_i)));

    assign instr_ready_o = ready_en_q && !full && (state_q == ST_RUN) && !flush_i;
    assign dec_valid_o   = !empty && !hazard && !flush_i;
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = dec_valid_o && dec_ready_i;

    assign instr_o    = head.dec;
    assign rs1_addr_o = head.rs1;
    assign rs2_addr_o = head.rs2;
    assign rd_addr_o  = head.rd;
    assign next_pc_o  = PC_WIDTH'(head.next_pc);
    assign illegal_o  = !empty && (head.dec.operation == OP_INVALID);
    assign count_o    = count_q;

    // Next-state: an accepted illegal instruction halts intake until flush.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && push && (push_entry.dec.operation == OP_INVALID)) begin
            state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage, pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_kamus_id_queue.sv
// Scoreboard bench for kamus_id_queue: expected decodes are queued on push
// and compared against the head every cycle until popped.
module tb_kamus_id_queue;
    import kamus_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;

    logic              clk_i, rst_ni;
    logic              instr_valid_i, instr_ready_o;
    logic [31:0]       instr_i;
    logic [PC_W-1:0]   instr_addr_i, next_pc_i, next_pc_o;
    logic              dec_valid_o, dec_ready_i, illegal_o;
    instr_decoded_t    instr_o;
    logic [4:0]        rs1_addr_o, rs2_addr_o, rd_addr_o, ex_load_rd_i;
    logic              flush_i, ex_load_valid_i;
    logic [$clog2(DEPTH):0] count_o;

    kamus_id_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .instr_addr_i(instr_addr_i), .next_pc_i(next_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .instr_o(instr_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .next_pc_o(next_pc_o), .illegal_o(illegal_o),
        .flush_i(flush_i), .ex_load_valid_i(ex_load_valid_i),
        .ex_load_rd_i(ex_load_rd_i), .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ins, pc, npc, imm;
        op_e         op;
        logic        used, r1u, r2u;
    } exp_t;

    exp_t tbl [13];
    exp_t sb [$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_halt  = 1'b0;
    bit   m_rdy_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input op_e op, input logic [31:0] imm,
                                input logic used, input logic r1u, input logic r2u);
        exp_t e;
        e.ins = ins; e.op = op; e.imm = imm; e.used = used; e.r1u = r1u; e.r2u = r2u;
        e.pc = '0; e.npc = '0;
        return e;
    endfunction

    task automatic offer(input int idx, input logic [31:0] pc);
        cur     = tbl[idx];
        cur.pc  = pc;
        cur.npc = pc + 32'd4;
        instr_valid_i = 1'b1;
        instr_i       = cur.ins;
        instr_addr_i  = pc;
        next_pc_i     = pc + 32'd4;
    endtask

    task automatic idle();
        instr_valid_i = 1'b0;
        instr_i       = '0;
        instr_addr_i  = '0;
        next_pc_i     = '0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        exp_t h;
        bit er, ev, hz, dp, dq;
        #1;
        er = m_rdy_en && (sb.size() < int'(DEPTH)) && !m_halt && !flush_i;
        hz = 1'b0;
        if (sb.size() > 0) begin
            h  = sb[0];
            hz = ex_load_valid_i && (ex_load_rd_i != 5'd0)
              && ((h.r1u && (h.ins[19:15] == ex_load_rd_i)) || (h.r2u && (h.ins[24:20] == ex_load_rd_i)));
        end
        ev = (sb.size() > 0) && !hz && !flush_i;
        check("instr_ready", 64'(instr_ready_o), 64'(er));
        check("dec_valid", 64'(dec_valid_o), 64'(ev));
        check("count", 64'(count_o), 64'(sb.size()));
        if (sb.size() > 0) begin
            check("operation", 64'(instr_o.operation), 64'(h.op));
            check("immediate", 64'(instr_o.immediate), 64'(h.imm));
            check("imm_used", 64'(instr_o.immediate_used), 64'(h.used));
            check("pc", 64'(instr_o.pc), 64'(h.pc));
            check("next_pc", 64'(next_pc_o), 64'(h.npc));
            check("rd", 64'(rd_addr_o), 64'(h.ins[11:7]));
            check("rs1", 64'(rs1_addr_o), 64'(h.ins[19:15]));
            check("rs2", 64'(rs2_addr_o), 64'(h.ins[24:20]));
            check("illegal", 64'(illegal_o), 64'(h.op == OP_INVALID));
        end else begin
            check("empty_head", 64'(|{instr_o, rs1_addr_o, rs2_addr_o, rd_addr_o, next_pc_o, illegal_o}), 64'(0));
        end
        dp = instr_valid_i && er;
        dq = ev && dec_ready_i;
        @(posedge clk_i);
        m_rdy_en = 1'b1;
        if (flush_i) begin
            sb.delete();
            m_halt = 1'b0;
        end else begin
            if (dq) void'(sb.pop_front());
            if (dp) begin
                sb.push_back(cur);
                if (cur.op == OP_INVALID) m_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        idle();
        dec_ready_i     = 1'b1;
        ex_load_valid_i = 1'b0;
        for (int i = 0; i < 3 * int'(DEPTH) && sb.size() > 0; i++) step();
        check("drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        int k;
        tbl[0]  = mk(32'h0050_0093, OP_ADD,     32'h0000_0005, 1, 1, 0);
        tbl[1]  = mk(32'h0011_01B3, OP_ADD,     32'h0000_0000, 0, 1, 1);
        tbl[2]  = mk(32'h0000_0000, OP_INVALID, 32'h0000_0000, 0, 1, 0);
        tbl[3]  = mk(32'h1234_52B7, OP_LUI,     32'h1234_5000, 1, 0, 0);
        tbl[4]  = mk(32'hFFF1_0113, OP_ADD,     32'hFFFF_FFFF, 1, 1, 0);
        tbl[5]  = mk(32'h0011_2423, OP_SW,      32'h0000_0008, 1, 1, 1);
        tbl[6]  = mk(32'hFE00_0EE3, OP_BEQ,     32'hFFFF_FFFC, 1, 1, 1);
        tbl[7]  = mk(32'h4062_8233, OP_SUB,     32'h0000_0000, 0, 1, 1);
        tbl[8]  = mk(32'h0100_00EF, OP_JAL,     32'h0000_0010, 1, 0, 0);
        tbl[9]  = mk(32'hFF81_A383, OP_LW,      32'hFFFF_FFF8, 1, 1, 0);
        tbl[10] = mk(32'h0000_0073, OP_ECALL,   32'h0000_0000, 0, 0, 0);
        tbl[11] = mk(32'h4030_D093, OP_SRA,     32'h0000_0003, 1, 1, 0);
        tbl[12] = mk(32'hFFFF_F517, OP_AUIPC,   32'hFFFF_F000, 1, 0, 0);

        rst_ni = 1'b0; flush_i = 1'b0; dec_ready_i = 1'b0;
        ex_load_valid_i = 1'b0; ex_load_rd_i = '0;
        idle();
        #3;
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_valid", 64'(dec_valid_o), 64'(0));
        check("rst_ready", 64'(instr_ready_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Single addi issues the cycle after it is pushed.
        dec_ready_i = 1'b1;
        offer(0, 32'h100); step();
        idle(); step();

        // Fill to full with EX stalled; a same-cycle pop does not open a slot for the offer.
        dec_ready_i = 1'b0;
        offer(1, 32'h200); step();
        offer(3, 32'h204); step();
        offer(4, 32'h208); step();
        offer(5, 32'h20C); step();
        idle(); step();
        check("full_count", 64'(count_o), 64'(DEPTH));
        dec_ready_i = 1'b1;
        offer(6, 32'h210); step();
        check("after_pop_count", 64'(count_o), 64'(DEPTH - 1));
        drain();

        // Load-use interlock on the head add x3,x2,x1.
        dec_ready_i = 1'b0;
        offer(1, 32'h300); step();
        idle();
        ex_load_valid_i = 1'b1;
        ex_load_rd_i = 5'd2; step();
        ex_load_rd_i = 5'd1; step();
        ex_load_rd_i = 5'd0; step();
        ex_load_rd_i = 5'd3; step();
        ex_load_valid_i = 1'b0;
        drain();

        // Illegal instruction halts intake; flush restores RUN.
        dec_ready_i = 1'b0;
        offer(2, 32'h400); step();
        offer(0, 32'h404); step();
        idle(); dec_ready_i = 1'b1; step();
        flush_i = 1'b1; step();
        flush_i = 1'b0; step();

        // Flush with a concurrent push empties the queue.
        dec_ready_i = 1'b0;
        offer(6, 32'h500); step();
        offer(7, 32'h504); step();
        offer(8, 32'h508); step();
        offer(9, 32'h50C); flush_i = 1'b1; step();
        flush_i = 1'b0; idle(); step();

        // Randomised traffic with stalls and load interlocks; exercises pointer wrap.
        pc = 32'h1000;
        for (int c = 0; c < 120; c++) begin
            dec_ready_i     = ($urandom_range(0, 3) != 0);
            ex_load_valid_i = $urandom_range(0, 1) != 0;
            ex_load_rd_i    = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                k = int'($urandom_range(0, 11));
                if (k >= 2) k = k + 1;
                offer(k, pc);
                pc = pc + 32'd4;
            end else begin
                idle();
            end
            step();
        end
        drain();

        // Asynchronous reset mid-cycle with entries queued.
        dec_ready_i = 1'b0;
        offer(10, 32'h600); step();
        offer(12, 32'h604); step();
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_valid", 64'(dec_valid_o), 64'(0));
        check("async_count", 64'(count_o), 64'(0));
        check("async_illegal", 64'(illegal_o), 64'(0));
        check("async_head", 64'(|{instr_o, rs1_addr_o, rs2_addr_o, rd_addr_o, next_pc_o}), 64'(0));
        sb.delete();
        m_halt = 1'b0;
        m_rdy_en = 1'b0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        step();
        dec_ready_i = 1'b1;
        offer(11, 32'h700); step();
        idle(); step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
